conv_filter_sched: RTL and testbench

CONV_FILTER_SCHED -- requirements
Module: conv_filter_sched

---
 rtl/conv_filter_sched_pkg.sv | 15 +
 rtl/valid_tag_pipe.sv | 46 ++++
 rtl/conv_filter_sched.sv | 129 ++++++++++++
 tb/tb_conv_filter_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_filter_sched_pkg.sv
// Shared conv package: default frame geometry, filter latency and the scheduler state encoding.
package conv_filter_sched_pkg;

  localparam int unsigned DEF_CH_NUM   = 32;
  localparam int unsigned DEF_PIX_NUM  = 676;
  localparam int unsigned DEF_FILT_LAT = 9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_WIN = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } sched_state_e;

endpackage

// File: rtl/valid_tag_pipe.sv
// Clearable valid/tag delay line: stage 0 is one cycle after the input, stage DEPTH-1 is the output.
module valid_tag_pipe #(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_valid,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_first_valid,
  output logic             o_last_valid,
  output logic [TAG_W-1:0] o_last_tag,
  output logic             o_pending_c
);

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [DEPTH];

  // Valid bits are the only state the flush has to clear; tags are don't-care without them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_clr) begin
      r_valid <= '0;
    end else begin
      r_valid <= {r_valid[DEPTH-2:0], i_valid};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= i_tag;
      for (int i = 1; i < int'(DEPTH); i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign o_first_valid = r_valid[0];
  assign o_last_valid  = r_valid[DEPTH-1];
  assign o_last_tag    = r_tag[DEPTH-1];
  // Anything still travelling toward the output after this cycle.
  assign o_pending_c   = |r_valid[DEPTH-2:0];

endmodule

// File: rtl/conv_filter_sched.sv
// Time-shares one 3x3 filter datapath over CH_NUM channels per window and tags results by channel/pixel.
module conv_filter_sched
  import conv_filter_sched_pkg::*;
#(
  parameter int unsigned CH_NUM   = DEF_CH_NUM,
  parameter int unsigned PIX_NUM  = DEF_PIX_NUM,
  parameter int unsigned FILT_LAT = DEF_FILT_LAT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       win_valid,
  output logic                       win_ready,
  output logic                       wt_rd_en,
  output logic [$clog2(CH_NUM)-1:0]  wt_addr,
  output logic                       flt_in_valid,
  output logic                       res_valid,
  output logic [$clog2(CH_NUM)-1:0]  res_ch,
  output logic [$clog2(PIX_NUM)-1:0] res_pix,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned CH_W  = $clog2(CH_NUM);
  localparam int unsigned PIX_W = $clog2(PIX_NUM);
  localparam int unsigned TAG_W = CH_W + PIX_W;
  localparam int unsigned DEPTH = FILT_LAT + 1;

  sched_state_e     r_state;
  logic [CH_W-1:0]  r_ch_cnt;
  logic [PIX_W-1:0] r_pix_cnt;
  logic             r_win_ready;
  logic             r_rd_en;
  logic             r_busy;
  logic             r_done;

  logic             w_pending;
  logic [TAG_W-1:0] w_res_tag;

  // Scheduler FSM; every output is a flop updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ch_cnt    <= '0;
      r_pix_cnt   <= '0;
      r_win_ready <= 1'b0;
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort) begin
      r_state     <= IDLE;
      r_ch_cnt    <= '0;
      r_pix_cnt   <= '0;
      r_win_ready <= 1'b0;
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ch_cnt    <= '0;
            r_pix_cnt   <= '0;
            r_busy      <= 1'b1;
            r_win_ready <= 1'b1;
            r_state     <= WAIT_WIN;
          end
        end
        WAIT_WIN: begin
          if (win_valid) begin
            r_ch_cnt    <= '0;
            r_win_ready <= 1'b0;
            r_rd_en     <= 1'b1;
            r_state     <= RUN;
          end
        end
        RUN: begin
          if (r_ch_cnt == CH_W'(CH_NUM - 1)) begin
            r_ch_cnt <= '0;
            r_rd_en  <= 1'b0;
            if (r_pix_cnt == PIX_W'(PIX_NUM - 1)) begin
              r_state <= DRAIN;
            end else begin
              r_pix_cnt   <= r_pix_cnt + PIX_W'(1);
              r_win_ready <= 1'b1;
              r_state     <= WAIT_WIN;
            end
          end else begin
            r_ch_cnt <= r_ch_cnt + CH_W'(1);
          end
        end
        DRAIN: begin
          // Last result is at the output now, so done lands the cycle after it.
          if (!w_pending) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  valid_tag_pipe #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clr         (abort),
    .i_valid       (r_rd_en),
    .i_tag         ({r_ch_cnt, r_pix_cnt}),
    .o_first_valid (flt_in_valid),
    .o_last_valid  (res_valid),
    .o_last_tag    (w_res_tag),
    .o_pending_c   (w_pending)
  );

  assign win_ready         = r_win_ready;
  assign wt_rd_en          = r_rd_en;
  assign wt_addr           = r_ch_cnt;
  assign {res_ch, res_pix} = w_res_tag;
  assign busy              = r_busy;
  assign done              = r_done;

endmodule

// File: tb/tb_conv_filter_sched.sv
// Bench for conv_filter_sched: timeline-schedule reference model checked every cycle plus directed literal checks.
module tb_conv_filter_sched;

  localparam int CH   = 4;
  localparam int PIX  = 2;
  localparam int FLAT = 9;
  localparam int BIG  = 32'h7fffffff;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       win_valid = 1'b0;
  logic       win_ready, wt_rd_en, flt_in_valid, res_valid, busy, done;
  logic [1:0] wt_addr, res_ch;
  logic [0:0] res_pix;

  conv_filter_sched #(.CH_NUM(CH), .PIX_NUM(PIX), .FILT_LAT(FLAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .wt_rd_en     (wt_rd_en),
    .wt_addr      (wt_addr),
    .flt_in_valid (flt_in_valid),
    .res_valid    (res_valid),
    .res_ch       (res_ch),
    .res_pix      (res_pix),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a timeline of planned events keyed by absolute cycle number.
  bit m_win [int];
  bit m_rd  [int];
  int m_addr[int];
  bit m_flt [int];
  bit m_res [int];
  int m_rch [int];
  int m_rpix[int];
  int m_done_at = -1;
  int m_bfrom = 1;
  int m_bto = 0;
  int m_pix = 0;

  // Observation log for the directed checks.
  int rd_cyc[$], rd_addr[$], res_cyc[$], res_ch_q[$], res_pix_q[$], done_cyc[$];
  int wr_cnt = 0;

  task automatic clear_plan();
    m_win.delete(); m_rd.delete(); m_addr.delete(); m_flt.delete();
    m_res.delete(); m_rch.delete(); m_rpix.delete();
    m_done_at = -1;
  endtask

  always @(negedge clk) begin
    bit e_wr, e_rd, e_flt, e_res, e_busy, e_done;
    cyc++;
    if (!rst_n) begin
      check({win_ready, wt_rd_en, flt_in_valid, res_valid, busy, done, wt_addr, res_ch, res_pix} == '0,
            "outputs_in_reset",
            int'({win_ready, wt_rd_en, flt_in_valid, res_valid, busy, done, wt_addr, res_ch, res_pix}), 0);
      clear_plan();
      m_bto = 0;
    end else begin
      e_wr   = m_win.exists(cyc);
      e_rd   = m_rd.exists(cyc);
      e_flt  = m_flt.exists(cyc);
      e_res  = m_res.exists(cyc);
      e_busy = (cyc >= m_bfrom) && (cyc < m_bto);
      e_done = (cyc == m_done_at);
      check(win_ready == e_wr,      "win_ready",    int'(win_ready),    int'(e_wr));
      check(wt_rd_en == e_rd,       "wt_rd_en",     int'(wt_rd_en),     int'(e_rd));
      check(flt_in_valid == e_flt,  "flt_in_valid", int'(flt_in_valid), int'(e_flt));
      check(res_valid == e_res,     "res_valid",    int'(res_valid),    int'(e_res));
      check(busy == e_busy,         "busy",         int'(busy),         int'(e_busy));
      check(done == e_done,         "done",         int'(done),         int'(e_done));
      if (e_rd) check(int'(wt_addr) == m_addr[cyc], "wt_addr", int'(wt_addr), m_addr[cyc]);
      if (e_res) begin
        check(int'(res_ch) == m_rch[cyc],   "res_ch",  int'(res_ch),  m_rch[cyc]);
        check(int'(res_pix) == m_rpix[cyc], "res_pix", int'(res_pix), m_rpix[cyc]);
      end

      if (wt_rd_en) begin rd_cyc.push_back(cyc); rd_addr.push_back(int'(wt_addr)); end
      if (res_valid) begin
        res_cyc.push_back(cyc); res_ch_q.push_back(int'(res_ch)); res_pix_q.push_back(int'(res_pix));
      end
      if (done) done_cyc.push_back(cyc);
      if (win_ready) wr_cnt++;

      if (m_win.exists(cyc)) m_win.delete(cyc);
      if (m_rd.exists(cyc)) begin m_rd.delete(cyc); m_addr.delete(cyc); end
      if (m_flt.exists(cyc)) m_flt.delete(cyc);
      if (m_res.exists(cyc)) begin m_res.delete(cyc); m_rch.delete(cyc); m_rpix.delete(cyc); end

      // Plan the future from the inputs the design samples at the coming edge.
      if (abort) begin
        clear_plan();
        if (m_bto > cyc + 1) m_bto = cyc + 1;
      end else if (!e_busy && start) begin
        m_bfrom = cyc + 1;
        m_bto   = BIG;
        m_pix   = 0;
        m_win[cyc+1] = 1'b1;
      end else if (e_wr) begin
        if (win_valid) begin
          for (int i = 0; i < CH; i++) begin
            int r;
            r = cyc + 1 + i;
            m_rd[r] = 1'b1; m_addr[r] = i;
            m_flt[r+1] = 1'b1;
            m_res[r+1+FLAT] = 1'b1; m_rch[r+1+FLAT] = i; m_rpix[r+1+FLAT] = m_pix;
          end
          if (m_pix < PIX - 1) begin
            m_win[cyc+CH+1] = 1'b1;
            m_pix++;
          end else begin
            m_done_at = cyc + CH + FLAT + 2;
            m_bto     = m_done_at;
          end
        end else begin
          m_win[cyc+1] = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin ok = 1'b1; break; end
    end
    check(ok, "done_within_budget", int'(ok), 1);
    tick(); tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0, s0, d0, w0;
    int offs[8];
    bit ok;
    int n3;
    offs = '{0, 1, 2, 3, 5, 6, 7, 8};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check(busy == 1'b0 && done == 1'b0, "idle_after_reset", int'({busy, done}), 0);

    // Frame with windows always available.
    r0 = rd_cyc.size(); s0 = res_cyc.size(); d0 = done_cyc.size(); w0 = wr_cnt;
    win_valid = 1'b1;
    pulse_start();
    wait_done(100);
    win_valid = 1'b0;
    check(rd_cyc.size() - r0 == 8, "a_read_count", rd_cyc.size() - r0, 8);
    check(res_cyc.size() - s0 == 8, "a_result_count", res_cyc.size() - s0, 8);
    check(done_cyc.size() - d0 == 1, "a_done_count", done_cyc.size() - d0, 1);
    check(wr_cnt - w0 == 2, "a_win_ready_cycles", wr_cnt - w0, 2);
    if (rd_cyc.size() - r0 == 8 && res_cyc.size() - s0 == 8 && done_cyc.size() - d0 == 1) begin
      for (int k = 0; k < 8; k++) begin
        check(rd_addr[r0+k] == k % 4, "a_wt_addr_seq", rd_addr[r0+k], k % 4);
        check(rd_cyc[r0+k] - rd_cyc[r0] == offs[k], "a_read_offset", rd_cyc[r0+k] - rd_cyc[r0], offs[k]);
        check(res_ch_q[s0+k] == k % 4, "a_res_ch_order", res_ch_q[s0+k], k % 4);
        check(res_pix_q[s0+k] == k / 4, "a_res_pix_order", res_pix_q[s0+k], k / 4);
        check(res_cyc[s0+k] - rd_cyc[r0+k] == 10, "a_read_to_result", res_cyc[s0+k] - rd_cyc[r0+k], 10);
      end
      check(done_cyc[d0] - rd_cyc[r0+7] == 11, "a_last_read_to_done", done_cyc[d0] - rd_cyc[r0+7], 11);
    end

    // Second window held off for five cycles.
    r0 = rd_cyc.size(); s0 = res_cyc.size();
    win_valid = 1'b1;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wt_rd_en) begin ok = 1'b1; break; end
      tick();
    end
    check(ok, "b_first_read_seen", int'(ok), 1);
    win_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (win_ready) begin ok = 1'b1; break; end
    end
    check(ok, "b_second_ready_seen", int'(ok), 1);
    repeat (5) tick();
    win_valid = 1'b1;
    wait_done(100);
    win_valid = 1'b0;
    check(rd_cyc.size() - r0 == 8, "b_read_count", rd_cyc.size() - r0, 8);
    check(res_cyc.size() - s0 == 8, "b_result_count", res_cyc.size() - s0, 8);
    if (rd_cyc.size() - r0 == 8)
      check(rd_cyc[r0+4] - rd_cyc[r0+3] == 7, "b_read_gap", rd_cyc[r0+4] - rd_cyc[r0+3], 7);

    // Abort mid-window at channel 2, then a clean frame.
    win_valid = 1'b1;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wt_rd_en && wt_addr == 2'd2) begin ok = 1'b1; break; end
      tick();
    end
    check(ok, "c_reached_ch2", int'(ok), 1);
    s0 = res_cyc.size(); d0 = done_cyc.size();
    abort = 1'b1; tick(); abort = 1'b0;
    check(busy == 1'b0, "c_busy_after_abort", int'(busy), 0);
    win_valid = 1'b0;
    repeat (20) tick();
    check(res_cyc.size() - s0 == 0, "c_no_results_after_abort", res_cyc.size() - s0, 0);
    check(done_cyc.size() - d0 == 0, "c_no_done_after_abort", done_cyc.size() - d0, 0);
    s0 = res_cyc.size(); d0 = done_cyc.size();
    win_valid = 1'b1;
    pulse_start();
    wait_done(100);
    win_valid = 1'b0;
    check(res_cyc.size() - s0 == 8, "c_clean_frame_results", res_cyc.size() - s0, 8);
    check(done_cyc.size() - d0 == 1, "c_clean_frame_done", done_cyc.size() - d0, 1);

    // Reset pulse while draining.
    win_valid = 1'b1;
    pulse_start();
    n3 = 0;
    for (int i = 0; i < 40 && n3 < 2; i++) begin
      if (wt_rd_en && wt_addr == 2'd3) n3++;
      if (n3 < 2) tick();
    end
    check(n3 == 2, "d_reached_last_read", n3, 2);
    win_valid = 1'b0;
    repeat (3) tick();
    s0 = res_cyc.size(); d0 = done_cyc.size();
    rst_n = 1'b0;
    #1;
    check({win_ready, wt_rd_en, flt_in_valid, res_valid, busy, done, wt_addr, res_ch, res_pix} == '0,
          "d_outputs_zero_on_reset",
          int'({win_ready, wt_rd_en, flt_in_valid, res_valid, busy, done, wt_addr, res_ch, res_pix}), 0);
    tick();
    rst_n = 1'b1;
    repeat (25) tick();
    check(res_cyc.size() - s0 == 0, "d_no_results_after_reset", res_cyc.size() - s0, 0);
    check(done_cyc.size() - d0 == 0, "d_no_done_after_reset", done_cyc.size() - d0, 0);

    // Start pulses while busy are ignored.
    s0 = res_cyc.size(); d0 = done_cyc.size();
    win_valid = 1'b1;
    pulse_start();
    repeat (3) tick();
    pulse_start();
    repeat (6) tick();
    pulse_start();
    wait_done(100);
    win_valid = 1'b0;
    check(res_cyc.size() - s0 == 8, "e_results_with_extra_starts", res_cyc.size() - s0, 8);
    check(done_cyc.size() - d0 == 1, "e_single_done", done_cyc.size() - d0, 1);

    // Randomised traffic, including aborts and occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 19) == 0);
      abort     = ($urandom_range(0, 149) == 0);
      win_valid = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 799) != 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; win_valid = 1'b0; rst_n = 1'b1;
    repeat (30) tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
